// File: rtl/wsr_pkg.sv
// Shared helpers for the window shift register: tap bit offsets and counter sizing.
package wsr_pkg;

  function automatic int cnt_w(input int size, input int stride);
    int m;
    m = (size > stride) ? size : stride;
    return $clog2(m + 1);
  endfunction

  // Bit offset of (channel, tap) in the flattened window bus; tap 0 is newest.
  function automatic int tap_off(input int ch, input int tap, input int size, input int dw);
    return (ch * size + tap) * dw;
  endfunction

endpackage

// File: rtl/window_shift_register_if.sv
// Input/output handshake bundle of the window shift register.
interface window_shift_register_if #(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 1
);
  localparam int FW = $clog2(SIZE + 1);

  logic                                in_valid;
  logic                                in_ready;
  logic [CHANNELS*DATA_WIDTH-1:0]      shift_in;
  logic                                out_valid;
  logic                                out_ready;
  logic [CHANNELS*SIZE*DATA_WIDTH-1:0] data_out;
  logic [CHANNELS*DATA_WIDTH-1:0]      shift_out;
  logic [FW-1:0]                       fill_count;

  modport master (
    output in_valid, shift_in, out_ready,
    input  in_ready, out_valid, data_out, shift_out, fill_count
  );

  modport slave (
    input  in_valid, shift_in, out_ready,
    output in_ready, out_valid, data_out, shift_out, fill_count
  );
endinterface

// File: rtl/wsr_lane.sv
// One channel's SIZE-deep tap chain; clear beats load beats shift.
// Load port exists only when WSR_PARALLEL_LOAD_EN is defined.
module wsr_lane
  import wsr_pkg::*;
#(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       r_reset,
  input  logic                       clr_i,
  input  logic                       shift_i,
  input  logic [DATA_WIDTH-1:0]      sample_i,
`ifdef WSR_PARALLEL_LOAD_EN
  input  logic                       load_i,
  input  logic [SIZE*DATA_WIDTH-1:0] load_data_i,
`endif
  output logic [SIZE*DATA_WIDTH-1:0] taps_o
);

  logic [SIZE-1:0][DATA_WIDTH-1:0] taps_q, taps_d;

  always_comb begin
    taps_d = taps_q;
    if (clr_i) taps_d = '0;
`ifdef WSR_PARALLEL_LOAD_EN
    else if (load_i) taps_d = load_data_i;
`endif
    else if (shift_i) taps_d = {taps_q[SIZE-2:0], sample_i};
  end

  always_ff @(posedge clock or negedge r_reset) begin
    if (!r_reset) taps_q <= '0;
    else          taps_q <= taps_d;
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/window_shift_register.sv
// Multi-channel tap-delay line with valid/ready, fill tracking, stride and clear.
// Optional parallel window load is enabled by WSR_PARALLEL_LOAD_EN.
module window_shift_register
  import wsr_pkg::*;
#(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 1,
  parameter int STRIDE     = 1
) (
  input  logic                                clock,
  input  logic                                r_reset,
  input  logic                                clear,
`ifdef WSR_PARALLEL_LOAD_EN
  input  logic                                load,
  input  logic [CHANNELS*SIZE*DATA_WIDTH-1:0] load_data,
`endif
  window_shift_register_if.slave              bus
);

  localparam int CW = cnt_w(SIZE, STRIDE);
  localparam int FW = $clog2(SIZE + 1);

  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] stride_q, stride_d;
  logic          out_valid_q, out_valid_d;

  logic in_ready, accept, load_en, shift_en, full_after, emit;

  logic [CHANNELS-1:0][SIZE*DATA_WIDTH-1:0] lane_taps;
  logic [CHANNELS*SIZE*DATA_WIDTH-1:0]      data_flat;
  logic [CHANNELS*DATA_WIDTH-1:0]           shift_out_w;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

`ifdef WSR_PARALLEL_LOAD_EN
  assign load_en = load && in_ready && !clear;
`else
  assign load_en = 1'b0;
`endif

  assign shift_en   = accept && !clear && !load_en;
  // This accept leaves the chain full; the first one to do so always emits.
  assign full_after = fill_q >= FW'(SIZE - 1);
  assign emit       = accept && full_after &&
                      ((fill_q != FW'(SIZE)) || (stride_q == CW'(STRIDE - 1)));

  always_comb begin
    fill_d      = fill_q;
    stride_d    = stride_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      fill_d      = '0;
      stride_d    = '0;
      out_valid_d = 1'b0;
    end else if (load_en) begin
      fill_d      = FW'(SIZE);
      stride_d    = '0;
      out_valid_d = 1'b1;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
      if (accept) begin
        if (fill_q != FW'(SIZE)) fill_d = fill_q + FW'(1);
        if (full_after)          stride_d = emit ? '0 : stride_q + CW'(1);
        if (emit)                out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge r_reset) begin
    if (!r_reset) begin
      fill_q      <= '0;
      stride_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      stride_q    <= stride_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    wsr_lane #(
      .SIZE       (SIZE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clock       (clock),
      .r_reset     (r_reset),
      .clr_i       (clear),
      .shift_i     (shift_en),
      .sample_i    (bus.shift_in[c*DATA_WIDTH +: DATA_WIDTH]),
`ifdef WSR_PARALLEL_LOAD_EN
      .load_i      (load_en),
      .load_data_i (load_data[c*SIZE*DATA_WIDTH +: SIZE*DATA_WIDTH]),
`endif
      .taps_o      (lane_taps[c])
    );
  end

  assign data_flat = lane_taps;

  always_comb begin
    shift_out_w = '0;
    for (int c = 0; c < CHANNELS; c++)
      shift_out_w[c*DATA_WIDTH +: DATA_WIDTH] =
        data_flat[tap_off(c, SIZE - 1, SIZE, DATA_WIDTH) +: DATA_WIDTH];
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.data_out   = data_flat;
  assign bus.shift_out  = shift_out_w;
  assign bus.fill_count = fill_q;

endmodule

// File: tb/tb_window_shift_register.sv
// Directed bench: STRIDE=1/CH=1, STRIDE=2/CH=1 and STRIDE=1/CH=2 instances on one clock.
module tb_window_shift_register;

  logic clk = 1'b0;
  logic r_reset;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  window_shift_register_if #(.SIZE(3), .DATA_WIDTH(32), .CHANNELS(1)) b0 ();
  window_shift_register_if #(.SIZE(3), .DATA_WIDTH(32), .CHANNELS(1)) b1 ();
  window_shift_register_if #(.SIZE(3), .DATA_WIDTH(32), .CHANNELS(2)) b2 ();

`ifdef WSR_PARALLEL_LOAD_EN
  logic         load0;
  logic [95:0]  ld0;
  logic         load_off;
  logic [95:0]  ld_off96;
  logic [191:0] ld_off192;
`endif

  window_shift_register #(.SIZE(3), .DATA_WIDTH(32), .CHANNELS(1), .STRIDE(1)) u0 (
    .clock(clk), .r_reset(r_reset), .clear(clear),
`ifdef WSR_PARALLEL_LOAD_EN
    .load(load0), .load_data(ld0),
`endif
    .bus(b0));

  window_shift_register #(.SIZE(3), .DATA_WIDTH(32), .CHANNELS(1), .STRIDE(2)) u1 (
    .clock(clk), .r_reset(r_reset), .clear(clear),
`ifdef WSR_PARALLEL_LOAD_EN
    .load(load_off), .load_data(ld_off96),
`endif
    .bus(b1));

  window_shift_register #(.SIZE(3), .DATA_WIDTH(32), .CHANNELS(2), .STRIDE(1)) u2 (
    .clock(clk), .r_reset(r_reset), .clear(clear),
`ifdef WSR_PARALLEL_LOAD_EN
    .load(load_off), .load_data(ld_off192),
`endif
    .bus(b2));

  function automatic logic [95:0] w3(input logic [31:0] t0, t1, t2);
    return {t2, t1, t0};
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    r_reset = 1'b0;
    clear   = 1'b0;
    b0.in_valid = 1'b0; b0.shift_in = '0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.shift_in = '0; b1.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.shift_in = '0; b2.out_ready = 1'b1;
`ifdef WSR_PARALLEL_LOAD_EN
    load0 = 1'b0; ld0 = '0; load_off = 1'b0; ld_off96 = '0; ld_off192 = '0;
`endif

    #2;
    chk("rst_fill",  b0.fill_count, 0);
    chk("rst_ov",    b0.out_valid,  0);
    chk("rst_ready", b0.in_ready,   1);
    chk("rst_data",  b0.data_out,   0);
    tick();
    r_reset = 1'b1;

    // fill with 5,6,7 then stream 8, gap, 9
    b0.in_valid = 1'b1; b0.shift_in = 32'd5; tick();
    chk("f1_fill", b0.fill_count, 1);
    chk("f1_ov",   b0.out_valid,  0);
    chk("f1_data", b0.data_out,   w3(5, 0, 0));
    b0.shift_in = 32'd6; tick();
    chk("f2_ov",   b0.out_valid,  0);
    b0.shift_in = 32'd7; tick();
    chk("w1_ov",   b0.out_valid,  1);
    chk("w1_data", b0.data_out,   w3(7, 6, 5));
    chk("w1_sout", b0.shift_out,  5);
    chk("w1_fill", b0.fill_count, 3);
    b0.shift_in = 32'd8; tick();
    chk("w2_ov",   b0.out_valid,  1);
    chk("w2_data", b0.data_out,   w3(8, 7, 6));
    b0.in_valid = 1'b0; tick();
    chk("gap_ov",   b0.out_valid, 0);
    chk("gap_data", b0.data_out,  w3(8, 7, 6));
    b0.in_valid = 1'b1; b0.shift_in = 32'd9; tick();
    chk("w3_ov",   b0.out_valid, 1);
    chk("w3_data", b0.data_out,  w3(9, 8, 7));
    chk("w3_sout", b0.shift_out, 7);

    // backpressure holds the window and refuses 10
    b0.out_ready = 1'b0; b0.shift_in = 32'd10; #1;
    chk("bp_ready", b0.in_ready, 0);
    repeat (4) tick();
    chk("bp_data", b0.data_out,   w3(9, 8, 7));
    chk("bp_ov",   b0.out_valid,  1);
    chk("bp_fill", b0.fill_count, 3);
    b0.out_ready = 1'b1; #1;
    chk("bp_rel_ready", b0.in_ready, 1);
    tick();
    chk("bp_rel_data", b0.data_out,  w3(10, 9, 8));
    chk("bp_rel_ov",   b0.out_valid, 1);

    // clear overrides a simultaneous accept
    clear = 1'b1; b0.shift_in = 32'd11; tick();
    chk("clr_fill",  b0.fill_count, 0);
    chk("clr_ov",    b0.out_valid,  0);
    chk("clr_data",  b0.data_out,   0);
    chk("clr_ready", b0.in_ready,   1);
    clear = 1'b0;
    b0.shift_in = 32'd1; tick();
    b0.shift_in = 32'd2; tick();
    chk("pre_ar_fill", b0.fill_count, 2);
    chk("pre_ar_data", b0.data_out,   w3(2, 1, 0));
    b0.in_valid = 1'b0;
    #2 r_reset = 1'b0;
    #1;
    chk("ar_fill", b0.fill_count, 0);
    chk("ar_data", b0.data_out,   0);
    chk("ar_ov",   b0.out_valid,  0);
    r_reset = 1'b1;
    tick();
    b0.in_valid = 1'b1; b0.shift_in = 32'd21; tick();
    b0.shift_in = 32'd22; tick();
    chk("rf2_ov", b0.out_valid, 0);
    b0.shift_in = 32'd23; tick();
    chk("rf3_ov",   b0.out_valid, 1);
    chk("rf3_data", b0.data_out,  w3(23, 22, 21));
    b0.in_valid = 1'b0; tick();

`ifdef WSR_PARALLEL_LOAD_EN
    load0 = 1'b1; ld0 = w3(9, 8, 7); tick();
    load0 = 1'b0;
    chk("ld_ov",   b0.out_valid,  1);
    chk("ld_data", b0.data_out,   w3(9, 8, 7));
    chk("ld_fill", b0.fill_count, 3);
`endif

    // STRIDE=2: windows at samples 3, 5, 7 only
    b1.in_valid = 1'b1;
    b1.shift_in = 32'd1; tick(); chk("s1_ov", b1.out_valid, 0);
    b1.shift_in = 32'd2; tick(); chk("s2_ov", b1.out_valid, 0);
    b1.shift_in = 32'd3; tick(); chk("s3_ov", b1.out_valid, 1);
    chk("s3_data", b1.data_out, w3(3, 2, 1));
    b1.shift_in = 32'd4; tick(); chk("s4_ov", b1.out_valid, 0);
    b1.shift_in = 32'd5; tick(); chk("s5_ov", b1.out_valid, 1);
    chk("s5_data", b1.data_out, w3(5, 4, 3));
    b1.shift_in = 32'd6; tick(); chk("s6_ov", b1.out_valid, 0);
    b1.shift_in = 32'd7; tick(); chk("s7_ov", b1.out_valid, 1);
    chk("s7_data", b1.data_out, w3(7, 6, 5));
    b1.in_valid = 1'b0;

    // two independent lanes
    b2.in_valid = 1'b1;
    b2.shift_in = {32'd101, 32'd1}; tick();
    b2.shift_in = {32'd102, 32'd2}; tick();
    chk("c2_ov", b2.out_valid, 0);
    b2.shift_in = {32'd103, 32'd3}; tick();
    chk("c3_ov",   b2.out_valid, 1);
    chk("c3_data", b2.data_out,  {w3(103, 102, 101), w3(3, 2, 1)});
    chk("c3_sout", b2.shift_out, {32'd101, 32'd1});
    b2.in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_shift_register.md
Name: window_shift_register

Overview:
- Parametrised, multi-channel tap-delay line for the convolver datapath. Successor to the basic SIZE×DATA_WIDTH shift register.
- Adds a valid/ready handshake, fill tracking, window stride, and synchronous clear.
- Presents all SIZE taps of every channel in parallel, so the downstream multiply-accumulate sees one complete window per handshake.

Parameters:
- SIZE, 3, taps per channel (≥2)
- DATA_WIDTH, 32, bits per sample
- CHANNELS, 1, independent lanes sharing one control path (≥1)
- STRIDE, 1, new accepted samples between emitted windows once full (≥1)

Ports:
- clock  in  1  rising-edge clock
- r_reset  in  1  reset; asynchronous, active-low
- clear  in  1  synchronous flush, active-high
- in_valid  in  1  shift_in holds a sample for every channel
- in_ready  out  1  block can accept a sample this cycle
- shift_in  in  CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  data_out holds an unconsumed window
- out_ready  in  1  consumer takes the window
- data_out  out  CHANNELS*SIZE*DATA_WIDTH  channel c, tap k at [(c*SIZE+k)*DATA_WIDTH +: DATA_WIDTH]; tap 0 newest
- shift_out  out  CHANNELS*DATA_WIDTH  tap SIZE-1 (oldest) of each channel
- fill_count  out  $clog2(SIZE+1)  valid taps held, saturates at SIZE

Behaviour:
- Reset (r_reset=0, async): all taps 0, fill_count 0, out_valid 0, stride counter 0. in_ready follows the rule below and is therefore 1.
- All outputs are registered-state driven. in_ready is combinational: in_ready = !out_valid || out_ready.
- Accept: accept = in_valid && in_ready.
  - On accept, every channel shifts: tap0 <= sample, tap k <= tap k-1. The old tap SIZE-1 is discarded.
  - fill_count increments, saturating at SIZE.
  - Latency: a sample appears at tap 0 on data_out one cycle after accept.
- Window emit:
  - An accept that leaves fill_count==SIZE (post-update) advances the stride counter.
  - The first such accept emits immediately, counter <= 0.
  - Thereafter, emit when counter==STRIDE-1, then counter <= 0; otherwise counter++.
  - Emit sets out_valid next cycle.
- Consume: out_valid && out_ready clears out_valid, unless an emitting accept occurs in the same cycle, in which case out_valid stays 1 with the new window.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0. Taps hold, data_out is stable, and in_valid is ignored.
- Non-emitting accepts during fill or stride gaps never raise out_valid.
- clear=1 (synchronous, priority over accept and consume): same state as reset. in_ready still reads per the formula, but no accept takes effect that cycle.
- Reset mid-operation: immediate return to the reset state. A pending window is lost and no handshake completes.
- in_valid=0: taps, fill_count and stride counter hold.
- STRIDE=1: every accept after full emits.
- Arithmetic: none on data. Counters are unsigned, width $clog2(max(SIZE,STRIDE)+1).

Optional Feature:
- Macro: WSR_PARALLEL_LOAD_EN.
- Defined: adds ports load (in, 1) and load_data (in, CHANNELS*SIZE*DATA_WIDTH, same layout as data_out).
  - load=1 and in_ready=1: all taps <= load_data, fill_count <= SIZE, stride counter <= 0, out_valid <= 1.
  - Priority: clear > load > accept.
  - load while in_ready=0 is ignored.
- Undefined: ports absent; shift-only behaviour as above.

Decomposition:
- Package wsr_pkg holds:
  - the tap-index helper function returning the bit offset of (channel, tap);
  - the counter-width localparam function.
- One sub-module, wsr_lane: a single-channel SIZE×DATA_WIDTH tap chain with shift enable, clear, and optional load. It is instantiated CHANNELS times under a shared control FSM/counters in the top.

Test Plan:
- SIZE=3, DW=32, CH=1, out_ready=1; release reset, push 5,6,7 on consecutive cycles.
  - out_valid rises the cycle after 7 is accepted; data_out taps = {7,6,5}; shift_out = 5; fill_count = 3.
- Continue pushing 8.
  - Window {8,7,6} with out_valid held; push 9 with in_valid=0 for one cycle in between → out_valid drops for that cycle.
- Backpressure: window {7,6,5} valid, out_ready=0, in_valid=1 with 8 for 4 cycles.
  - in_ready=0, taps unchanged; raise out_ready → 8 accepted same cycle, next window {8,7,6}.
- STRIDE=2, SIZE=3: push 1..7 with out_ready=1.
  - Windows only for {3,2,1}, {5,4,3}, {7,6,5}.
- CH=2: push ch0=1/ch1=101, ch0=2/ch1=102, ch0=3/ch1=103.
  - Lanes independent: ch0 {3,2,1}, ch1 {103,102,101}.
- clear asserted mid-window (fill=2), then assert r_reset low asynchronously mid-cycle.
  - fill_count→0, out_valid→0, all taps 0; refill requires 3 fresh samples.
  - With WSR_PARALLEL_LOAD_EN: load {9,8,7} → out_valid=1 the next cycle.
